decode: RTL and testbench

Second stage of the five-stage RV32I pipeline: consumes the fetch stage's `pcD`/`instrD`/`validD`, decodes the instruction, reads the 32-entry integer register file and generates the immediate and control word. It registers everything into the D/E pipeline register that feeds execute. It also hosts the register-file write port driven by writeback.

---
 rtl/decode.sv | 235 +++++++++++++++++++++++
 tb/tb_decode.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode -- RV32I decode stage with integer register file and D/E register.
//
// Decodes the fetched instruction, reads two operands from the 32-entry
// register file, builds the sign-extended immediate and the control word, and
// registers everything into the D/E pipeline register feeding execute. The
// register-file write port (driven by writeback) also lives here.
//
// Ports
//   clk, reset         pipeline clock; asynchronous active-low reset
//   en, flushE         D/E load enable (0 = stall); bubble insert (wins over en)
//   pcD, instrD, validD  instruction from fetch
//   regwriteW, rdW, resultW  writeback write port
//   pcE, rs1valE, rs2valE, immE  registered PC, operands, immediate
//   rs1E, rs2E, rdE    register indices for the hazard unit (0 if unused)
//   aluopE, funct3E    {funct7[5] qualifier, funct3}; branch/load/store subtype
//   alusrcaE, alusrcE  operand A is PC; operand B is immediate
//   regwriteE, memreadE, memwriteE, branchE, jumpE  control flags
//   validE, illegalE   valid instruction; unrecognised opcode
//
// Configuration macro: DECODE_REGFILE_BYPASS_EN
//   defined   -> a same-cycle writeback to a source register is forwarded
//   undefined -> reads return the pre-edge register-file contents
// -----------------------------------------------------------------------------
`ifndef WORD
`define WORD 32
`endif

module decode (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flushE,
  input  logic [`WORD-1:0]  pcD,
  input  logic [`WORD-1:0]  instrD,
  input  logic              validD,
  input  logic              regwriteW,
  input  logic [4:0]        rdW,
  input  logic [`WORD-1:0]  resultW,
  output logic [`WORD-1:0]  pcE,
  output logic [`WORD-1:0]  rs1valE,
  output logic [`WORD-1:0]  rs2valE,
  output logic [`WORD-1:0]  immE,
  output logic [4:0]        rs1E,
  output logic [4:0]        rs2E,
  output logic [4:0]        rdE,
  output logic [3:0]        aluopE,
  output logic [2:0]        funct3E,
  output logic              alusrcaE,
  output logic              alusrcE,
  output logic              regwriteE,
  output logic              memreadE,
  output logic              memwriteE,
  output logic              branchE,
  output logic              jumpE,
  output logic              validE,
  output logic              illegalE
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [`WORD-1:0] pc;
    logic [`WORD-1:0] rs1val;
    logic [`WORD-1:0] rs2val;
    logic [`WORD-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [3:0]       aluop;
    logic [2:0]       funct3;
    logic             alusrca;
    logic             alusrc;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic             jump;
    logic             valid;
    logic             illegal;
  } de_t;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [`WORD-1:0] rf_q [32];

  // NOTE: the array is cleared by reset because the reset state of every entry
  // is architecturally visible here; most RAM-style memories must not be reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (regwriteW && (rdW != 5'd0)) begin
      // Writeback commits regardless of en/flushE.
      rf_q[rdW] <= resultW;
    end
  end

  function automatic logic [`WORD-1:0] rf_read(input logic [4:0] idx);
    logic [`WORD-1:0] val;
    val = (idx == 5'd0) ? '0 : rf_q[idx];
`ifdef DECODE_REGFILE_BYPASS_EN
    if (regwriteW && (rdW != 5'd0) && (rdW == idx)) val = resultW;
`endif
    return val;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction fields and immediates
  // ---------------------------------------------------------------------------
  opcode_e          opcode;
  logic [2:0]       f3;
  logic [`WORD-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = opcode_e'(instrD[6:0]);
  assign f3     = instrD[14:12];
  assign imm_i  = {{20{instrD[31]}}, instrD[31:20]};
  assign imm_s  = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
  assign imm_b  = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25],
                   instrD[11:8], 1'b0};
  assign imm_u  = {instrD[31:12], 12'b0};
  assign imm_j  = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20],
                   instrD[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Decode. Index fields stay 0 for formats that lack them, so the hazard unit
  // sees no false dependency and unused operands read x0.
  // ---------------------------------------------------------------------------
  de_t dec;
  de_t de_d;
  de_t de_q;

  // NOTE: every field gets a default before the case so no path leaves a
  // field unassigned, which would otherwise infer a latch.
  always_comb begin
    dec       = '0;
    dec.pc    = pcD;
    dec.valid = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec.rd = instrD[11:7]; dec.imm = imm_u;
        dec.alusrc = 1'b1; dec.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd = instrD[11:7]; dec.imm = imm_u;
        dec.alusrca = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
      end
      OPC_JAL: begin
        dec.rd = instrD[11:7]; dec.imm = imm_j;
        dec.alusrca = 1'b1; dec.alusrc = 1'b1;
        dec.regwrite = 1'b1; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        dec.rd = instrD[11:7]; dec.rs1 = instrD[19:15]; dec.imm = imm_i;
        dec.funct3 = f3; dec.alusrc = 1'b1;
        dec.regwrite = 1'b1; dec.jump = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1 = instrD[19:15]; dec.rs2 = instrD[24:20]; dec.imm = imm_b;
        dec.funct3 = f3; dec.aluop = 4'b1000; dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        dec.rd = instrD[11:7]; dec.rs1 = instrD[19:15]; dec.imm = imm_i;
        dec.funct3 = f3; dec.alusrc = 1'b1;
        dec.regwrite = 1'b1; dec.memread = 1'b1;
      end
      OPC_STORE: begin
        dec.rs1 = instrD[19:15]; dec.rs2 = instrD[24:20]; dec.imm = imm_s;
        dec.funct3 = f3; dec.alusrc = 1'b1; dec.memwrite = 1'b1;
      end
      OPC_OPIMM: begin
        dec.rd = instrD[11:7]; dec.rs1 = instrD[19:15]; dec.imm = imm_i;
        dec.funct3 = f3; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
        // Only the shifts carry funct7[5]; ADDI must never turn into SUB.
        dec.aluop = {(f3 == 3'b101) & instrD[30], f3};
      end
      OPC_OP: begin
        dec.rd = instrD[11:7]; dec.rs1 = instrD[19:15]; dec.rs2 = instrD[24:20];
        dec.funct3 = f3; dec.regwrite = 1'b1;
        dec.aluop = {instrD[30], f3};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rs1val = rf_read(dec.rs1);
    dec.rs2val = rf_read(dec.rs2);

    // An invalid D-stage slot loads exactly what a flush would.
    de_d = validD ? dec : '0;
  end

  // ---------------------------------------------------------------------------
  // D/E pipeline register: reset > flush > enable > hold
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_q <= '0;
    end else if (flushE) begin
      de_q <= '0;
    end else if (en) begin
      de_q <= de_d;
    end
  end

  assign pcE       = de_q.pc;
  assign rs1valE   = de_q.rs1val;
  assign rs2valE   = de_q.rs2val;
  assign immE      = de_q.imm;
  assign rs1E      = de_q.rs1;
  assign rs2E      = de_q.rs2;
  assign rdE       = de_q.rd;
  assign aluopE    = de_q.aluop;
  assign funct3E   = de_q.funct3;
  assign alusrcaE  = de_q.alusrca;
  assign alusrcE   = de_q.alusrc;
  assign regwriteE = de_q.regwrite;
  assign memreadE  = de_q.memread;
  assign memwriteE = de_q.memwrite;
  assign branchE   = de_q.branch;
  assign jumpE     = de_q.jump;
  assign validE    = de_q.valid;
  assign illegalE  = de_q.illegal;

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode -- scoreboard bench for the decode stage.
// The stimulus process drives inputs on the falling edge and pushes the
// expected D/E contents (from a behavioural RV32I model) into a queue; the
// monitor pops one entry after each rising edge and compares all outputs.
// -----------------------------------------------------------------------------
`ifndef WORD
`define WORD 32
`endif

module tb_decode;

  typedef struct packed {
    logic [31:0] pc, rs1val, rs2val, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluop;
    logic [2:0]  funct3;
    logic alusrca, alusrc, regwrite, memread, memwrite, branch, jump, valid, illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, en, flushE, validD, regwriteW;
  logic [31:0] pcD, instrD, resultW;
  logic [4:0]  rdW;
  logic [31:0] pcE, rs1valE, rs2valE, immE;
  logic [4:0]  rs1E, rs2E, rdE;
  logic [3:0]  aluopE;
  logic [2:0]  funct3E;
  logic alusrcaE, alusrcE, regwriteE, memreadE, memwriteE, branchE, jumpE, validE, illegalE;

  int n_vec  = 0;
  int n_miss = 0;

  exp_t        exp_q[$];
  exp_t        st;          // model of the D/E contents
  logic [31:0] mrf [32];    // model of the register file

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .reset(reset), .en(en), .flushE(flushE),
    .pcD(pcD), .instrD(instrD), .validD(validD),
    .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
    .pcE(pcE), .rs1valE(rs1valE), .rs2valE(rs2valE), .immE(immE),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .aluopE(aluopE), .funct3E(funct3E),
    .alusrcaE(alusrcaE), .alusrcE(alusrcE), .regwriteE(regwriteE),
    .memreadE(memreadE), .memwriteE(memwriteE), .branchE(branchE),
    .jumpE(jumpE), .validE(validE), .illegalE(illegalE)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
`ifdef DECODE_REGFILE_BYPASS_EN
    if (regwriteW && rdW == idx) return resultW;
`endif
    return mrf[idx];
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e = '0;
    e.pc = pc;
    e.valid = 1'b1;
    case (ins[6:0])
      7'h37: begin e.rd = ins[11:7]; e.imm = {ins[31:12], 12'h000}; e.alusrc = 1; e.regwrite = 1; end
      7'h17: begin e.rd = ins[11:7]; e.imm = {ins[31:12], 12'h000}; e.alusrca = 1; e.alusrc = 1; e.regwrite = 1; end
      7'h6f: begin e.rd = ins[11:7]; e.imm = 32'(int'(j21)); e.alusrca = 1; e.alusrc = 1; e.regwrite = 1; e.jump = 1; end
      7'h67: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.imm = 32'(int'(i12)); e.funct3 = ins[14:12];
                   e.alusrc = 1; e.regwrite = 1; e.jump = 1; end
      7'h63: begin e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = 32'(int'(b13)); e.funct3 = ins[14:12];
                   e.aluop = 4'b1000; e.branch = 1; end
      7'h03: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.imm = 32'(int'(i12)); e.funct3 = ins[14:12];
                   e.alusrc = 1; e.regwrite = 1; e.memread = 1; end
      7'h23: begin e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = 32'(int'(s12)); e.funct3 = ins[14:12];
                   e.alusrc = 1; e.memwrite = 1; end
      7'h13: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.imm = 32'(int'(i12)); e.funct3 = ins[14:12];
                   e.alusrc = 1; e.regwrite = 1;
                   e.aluop = {(ins[14:12] == 3'b101) ? ins[30] : 1'b0, ins[14:12]}; end
      7'h33: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.funct3 = ins[14:12];
                   e.regwrite = 1; e.aluop = {ins[30], ins[14:12]}; end
      default: e.illegal = 1'b1;
    endcase
    e.rs1val = model_read(e.rs1);
    e.rs2val = model_read(e.rs2);
    return e;
  endfunction

  // Drive one cycle of inputs (called just after a falling edge) and push the
  // D/E contents expected after the following rising edge.
  task automatic apply(input logic rst, input logic e, input logic fl,
                       input logic [31:0] pc, input logic [31:0] ins, input logic vd,
                       input logic wr, input logic [4:0] rdw, input logic [31:0] res);
    exp_t cand;
    reset = rst; en = e; flushE = fl; pcD = pc; instrD = ins; validD = vd;
    regwriteW = wr; rdW = rdw; resultW = res;
    if (!rst) begin
      st = '0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    end else begin
      cand = vd ? model_decode(ins, pc) : '0;
      if (fl)     st = '0;
      else if (e) st = cand;
      if (wr && rdw != 0) mrf[rdw] = res;
    end
    exp_q.push_back(st);
  endtask

  task automatic step(input logic e, input logic fl, input logic [31:0] ins,
                      input logic wr, input logic [4:0] rdw, input logic [31:0] res);
    @(negedge clk);
    apply(1'b1, e, fl, $urandom, ins, 1'b1, wr, rdw, res);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opc [9];
    int k;
    opc = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    ins = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) ins[6:0] = opc[k];
    return ins;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string nm, input int vec, input logic [31:0] act,
                       input logic [31:0] expv, output bit bad);
    bad = (act !== expv);
    if (bad) $display("FAIL vec %0d %s: got 0x%08h expected 0x%08h", vec, nm, act, expv);
  endtask

  initial begin : monitor
    exp_t e;
    bit b, any;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        any = 0;
        check("pcE",       n_vec, pcE,       e.pc,       b); any |= b;
        check("rs1valE",   n_vec, rs1valE,   e.rs1val,   b); any |= b;
        check("rs2valE",   n_vec, rs2valE,   e.rs2val,   b); any |= b;
        check("immE",      n_vec, immE,      e.imm,      b); any |= b;
        check("rs1E",      n_vec, 32'(rs1E), 32'(e.rs1), b); any |= b;
        check("rs2E",      n_vec, 32'(rs2E), 32'(e.rs2), b); any |= b;
        check("rdE",       n_vec, 32'(rdE),  32'(e.rd),  b); any |= b;
        check("aluopE",    n_vec, 32'(aluopE),  32'(e.aluop),  b); any |= b;
        check("funct3E",   n_vec, 32'(funct3E), 32'(e.funct3), b); any |= b;
        check("flags", n_vec,
              32'({alusrcaE, alusrcE, regwriteE, memreadE, memwriteE, branchE, jumpE, validE, illegalE}),
              32'({e.alusrca, e.alusrc, e.regwrite, e.memread, e.memwrite, e.branch, e.jump, e.valid, e.illegal}),
              b); any |= b;
        n_vec++;
        if (any) n_miss++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int waited;
    reset = 0; en = 0; flushE = 0; pcD = 0; instrD = 0; validD = 0;
    regwriteW = 0; rdW = 0; resultW = 0;
    st = '0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;

    // Reset held with toggling inputs (including writes that must be ignored).
    repeat (4) begin
      @(negedge clk);
      apply(1'b0, 1'b1, $urandom_range(0, 1), $urandom, rand_instr(), 1'b1,
            1'b1, 5'($urandom), $urandom);
    end

    // After release every register reads 0.
    for (int i = 1; i < 32; i++)
      step(1, 0, {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33}, 0, 0, 0);

    // ADDI x1,x0,5
    step(1, 0, 32'h00500093, 0, 0, 0);
    // Same-cycle write x1=0x1234 with add x2,x1,x1, then re-decode.
    step(1, 0, 32'h00108133, 1, 5'd1, 32'h0000_1234);
    step(1, 0, 32'h00108133, 0, 0, 0);
    // Write to x0 dropped, then add x3,x0,x0.
    step(1, 0, 32'h00000013, 1, 5'd0, 32'h0000_FFFF);
    step(1, 0, 32'h000001B3, 0, 0, 0);
    // Branch and illegal.
    step(1, 0, 32'hFE000EE3, 0, 0, 0);
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0);
    // Stall for 3 cycles on a store, with writes still committing.
    step(1, 0, 32'h0020A223, 0, 0, 0);
    repeat (3) step(0, 0, rand_instr(), 1, 5'($urandom_range(1, 31)), $urandom);
    // Flush while stalled.
    step(0, 1, 32'h0020A223, 0, 0, 0);
    step(1, 0, 32'h00500093, 0, 0, 0);
    // validD low loads a bubble.
    @(negedge clk);
    apply(1'b1, 1'b1, 1'b0, 32'h100, 32'h00500093, 1'b0, 1'b0, 5'd0, 32'd0);

    // Randomized traffic with an occasional mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 10), $urandom, rand_instr(),
            ($urandom_range(0, 99) < 90), $urandom_range(0, 1),
            5'($urandom), $urandom);
    end

    @(negedge clk);
    reset = 1; en = 0; flushE = 0; regwriteW = 0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      n_miss++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
